// File: rtl/shift_register_sequencer_pkg.sv
// Shared types and constants for the shift register sequencer.
package shift_register_sequencer_pkg;

  // Command operations; encodings 5-7 are illegal.
  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SHR  = 3'd1,
    OP_SHL  = 3'd2,
    OP_ROTR = 3'd3,
    OP_ROTL = 3'd4
  } cmd_op_e;

  // Opcodes understood by the universal shift register datapath.
  localparam logic [1:0] USR_HOLD = 2'b00;
  localparam logic [1:0] USR_SHR  = 2'b01;
  localparam logic [1:0] USR_SHL  = 2'b10;
  localparam logic [1:0] USR_LOAD = 2'b11;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

endpackage

// File: rtl/shift_register_sequencer_if.sv
// Command channel between a requester (master) and the sequencer (slave).
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; the master holds cmd_* stable while cmd_valid is
// high and ready is low. done/err are single-cycle completion pulses.
interface shift_register_sequencer_if #(
  parameter int N  = 8,
  parameter int CW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic [N-1:0]  cmd_data;
  logic          cmd_fill;
  logic          done;
  logic          err;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill,
    input  cmd_ready, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill,
    output cmd_ready, done, err
  );
endinterface

// File: rtl/shift_step_counter.sv
// Loadable down-counter with a zero flag; counts EXEC steps remaining.
module shift_step_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);
  logic [CW-1:0] count_q, count_d;

  // Load has priority over decrement; decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);
endmodule

// File: rtl/shift_register_sequencer.sv
// Sequences LOAD/shift/rotate commands onto a universal shift register.
module shift_register_sequencer
  import shift_register_sequencer_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  shift_register_sequencer_if.slave   cmd,
  output logic [1:0]                  usr_opcode,
  output logic [N-1:0]                usr_parallel_in,
  output logic                        usr_msb_in,
  output logic                        usr_lsb_in,
  input  logic [N-1:0]                usr_out,
  output state_e                      dbg_state
);
  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [N-1:0]  data_q, data_d;
  logic          fill_q, fill_d;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_load_val;

  // Only usr_out[0] and usr_out[N-1] feed back; the rest is intentionally unused.
  logic unused_usr_out;
  assign unused_usr_out = ^usr_out;

  // The counter holds "steps remaining after this one", so EXEC ends on zero.
  shift_step_counter #(.CW(CW)) u_step_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state logic, command latching and step counter control.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    data_d       = data_q;
    fill_d       = fill_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d     = cmd.cmd_op;
          data_d   = cmd.cmd_data;
          fill_d   = cmd.cmd_fill;
          cnt_load = 1'b1;
          if (!op_is_legal(cmd.cmd_op)) begin
            state_d = ST_DONE;
          end else if (cmd.cmd_op == OP_LOAD) begin
            state_d = ST_EXEC;
          end else if (cmd.cmd_count == '0) begin
            state_d = ST_DONE;
          end else begin
            cnt_load_val = cmd.cmd_count - CW'(1);
            state_d      = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched command fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
    end
  end

  // Datapath drive decoded from state and latched fields only.
  always_comb begin
    usr_opcode      = USR_HOLD;
    usr_parallel_in = '0;
    usr_msb_in      = 1'b0;
    usr_lsb_in      = 1'b0;
    if (state_q == ST_EXEC) begin
      unique case (op_q)
        OP_LOAD: begin
          usr_opcode      = USR_LOAD;
          usr_parallel_in = data_q;
        end
        OP_SHR: begin
          usr_opcode = USR_SHR;
          usr_msb_in = fill_q;
        end
        OP_SHL: begin
          usr_opcode = USR_SHL;
          usr_lsb_in = fill_q;
        end
        OP_ROTR: begin
          usr_opcode = USR_SHR;
          usr_msb_in = usr_out[0];
        end
        OP_ROTL: begin
          usr_opcode = USR_SHL;
          usr_lsb_in = usr_out[N-1];
        end
        default: usr_opcode = USR_HOLD;
      endcase
    end
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign cmd.done      = (state_q == ST_DONE);
  assign cmd.err       = (state_q == ST_DONE) && !op_is_legal(op_q);
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_shift_register_sequencer.sv
// Directed bench: sequencer driving a universal shift register model (N=8).
module tb_shift_register_sequencer;
  import shift_register_sequencer_pkg::*;

  localparam int N  = 8;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_register_sequencer_if #(.N(N), .CW(CW)) cmd_bus ();

  logic [1:0]   usr_opcode;
  logic [N-1:0] usr_parallel_in;
  logic         usr_msb_in, usr_lsb_in;
  logic [N-1:0] dp_q;
  state_e       dbg_state;

  shift_register_sequencer #(.N(N), .CW(CW)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .cmd             (cmd_bus),
    .usr_opcode      (usr_opcode),
    .usr_parallel_in (usr_parallel_in),
    .usr_msb_in      (usr_msb_in),
    .usr_lsb_in      (usr_lsb_in),
    .usr_out         (dp_q),
    .dbg_state       (dbg_state)
  );

  // Universal shift register datapath; not reset by the sequencer.
  initial dp_q = '0;
  always_ff @(posedge clk) begin
    case (usr_opcode)
      2'b01:   dp_q <= {usr_msb_in, dp_q[N-1:1]};
      2'b10:   dp_q <= {dp_q[N-2:0], usr_lsb_in};
      2'b11:   dp_q <= usr_parallel_in;
      default: dp_q <= dp_q;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one command, then measures EXEC cycles, opcode, err and latency.
  task automatic issue(input string tag, input logic [2:0] op, input logic [CW-1:0] cnt,
                       input logic [N-1:0] data, input logic fill, input int exp_exec,
                       input logic [1:0] exp_opc, input logic exp_err, input logic [N-1:0] exp_reg);
    int guard, cyc, exec_cycles;
    logic opc_ok, pin_ok, got_done, got_err;
    exp_q.push_back(32'(exp_reg));
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_count = cnt;
    cmd_bus.cmd_data  = data;
    cmd_bus.cmd_fill  = fill;
    guard = 0;
    while (!cmd_bus.cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, 32'(cmd_bus.cmd_ready), 32'd1);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    cyc = 0; exec_cycles = 0; opc_ok = 1'b1; pin_ok = 1'b1; got_done = 1'b0; got_err = 1'b0;
    while (cyc < 64) begin
      cyc++;
      if (cmd_bus.done) begin
        got_done = 1'b1;
        got_err  = cmd_bus.err;
        break;
      end
      if (usr_opcode != 2'b00) begin
        exec_cycles++;
        if (usr_opcode != exp_opc) opc_ok = 1'b0;
        if (op == OP_LOAD && usr_parallel_in != data) pin_ok = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(got_done), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_exec + 1));
    check({tag, "_exec"}, 32'(exec_cycles), 32'(exp_exec));
    if (exp_exec > 0) check({tag, "_opcode"}, 32'(opc_ok), 32'd1);
    if (op == OP_LOAD) check({tag, "_pin"}, 32'(pin_ok), 32'd1);
    check({tag, "_err"}, 32'(got_err), 32'(exp_err));
    check({tag, "_usr_idle"}, 32'({usr_opcode, usr_parallel_in, usr_msb_in, usr_lsb_in}), 32'd0);
    @(negedge clk);
    check({tag, "_post"}, 32'({cmd_bus.done, cmd_bus.cmd_ready}), 32'b01);
    check({tag, "_reg"}, 32'(dp_q), exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic ready_low, saw_done;
    rst = 1'b1;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = '0;
    cmd_bus.cmd_count = '0;
    cmd_bus.cmd_data  = '0;
    cmd_bus.cmd_fill  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
    check("rst_done_err", 32'({cmd_bus.done, cmd_bus.err}), 32'd0);
    check("rst_opcode", 32'(usr_opcode), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    issue("load_a5",  OP_LOAD, 4'd0, 8'hA5, 1'b0, 1, 2'b11, 1'b0, 8'hA5);
    issue("shr3",     OP_SHR,  4'd3, 8'h00, 1'b1, 3, 2'b01, 1'b0, 8'hF4);
    issue("load_a5b", OP_LOAD, 4'd5, 8'hA5, 1'b0, 1, 2'b11, 1'b0, 8'hA5);
    issue("rotl4",    OP_ROTL, 4'd4, 8'hFF, 1'b0, 4, 2'b10, 1'b0, 8'h5A);
    issue("load_81",  OP_LOAD, 4'd0, 8'h81, 1'b0, 1, 2'b11, 1'b0, 8'h81);
    issue("rotr1",    OP_ROTR, 4'd1, 8'h00, 1'b0, 1, 2'b01, 1'b0, 8'hC0);
    issue("shl0",     OP_SHL,  4'd0, 8'h00, 1'b1, 0, 2'b10, 1'b0, 8'hC0);
    issue("op6",      3'd6,    4'd3, 8'h12, 1'b1, 0, 2'b00, 1'b1, 8'hC0);
    issue("load_01",  OP_LOAD, 4'd0, 8'h01, 1'b0, 1, 2'b11, 1'b0, 8'h01);
    issue("rotl10",   OP_ROTL, 4'd10, 8'h00, 1'b0, 10, 2'b10, 1'b0, 8'h04);
    issue("shr15",    OP_SHR,  4'd15, 8'h00, 1'b0, 15, 2'b01, 1'b0, 8'h00);

    // cmd_valid held high through a 5-step shift; inputs changed mid-command.
    issue("load_0f",  OP_LOAD, 4'd0, 8'h0F, 1'b0, 1, 2'b11, 1'b0, 8'h0F);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = OP_SHL;
    cmd_bus.cmd_count = 4'd5;
    cmd_bus.cmd_data  = 8'h00;
    cmd_bus.cmd_fill  = 1'b0;
    @(negedge clk);
    cmd_bus.cmd_op   = OP_LOAD;
    cmd_bus.cmd_data = 8'h3C;
    ready_low = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      if (cmd_bus.cmd_ready) ready_low = 1'b0;
      if (cmd_bus.done) break;
      @(negedge clk);
      cyc++;
    end
    check("hold_ready_low", 32'(ready_low), 32'd1);
    check("hold_exec", 32'(cyc), 32'd5);
    check("hold_reg", 32'(dp_q), 32'h0000_00E0);
    @(negedge clk);
    check("hold_ready_again", 32'(cmd_bus.cmd_ready), 32'd1);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    check("hold_second_op", 32'({usr_opcode, usr_parallel_in}), 32'({2'b11, 8'h3C}));
    @(negedge clk);
    check("hold_second_done", 32'(cmd_bus.done), 32'd1);
    check("hold_second_reg", 32'(dp_q), 32'h0000_003C);

    // Reset in the second EXEC cycle of SHL count=6 aborts the command.
    issue("load_81b", OP_LOAD, 4'd0, 8'h81, 1'b0, 1, 2'b11, 1'b0, 8'h81);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = OP_SHL;
    cmd_bus.cmd_count = 4'd6;
    cmd_bus.cmd_fill  = 1'b1;
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_exec2", 32'(usr_opcode), 32'(2'b10));
    rst = 1'b1;
    @(negedge clk);
    check("abort_opcode", 32'(usr_opcode), 32'd0);
    check("abort_ready", 32'(cmd_bus.cmd_ready), 32'd1);
    check("abort_done", 32'(cmd_bus.done), 32'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (cmd_bus.done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_reg", 32'(dp_q), 32'h0000_0007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
